muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_if.sv | 24 ++
 rtl/muldiv_core.sv | 61 ++++++
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: RV32M funct3 op codes, FSM state encoding and small
// decode helpers shared by muldiv_unit and muldiv_core.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic is_div_op(input logic [2:0] f);
    return f[2];
  endfunction

  function automatic logic rs1_signed(input logic [2:0] f);
    return (f == F3_MULH) || (f == F3_MULHSU) ||
           (f == F3_DIV)  || (f == F3_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] f);
    return (f == F3_MULH) || (f == F3_DIV) ||
           (f == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the core pipeline and
// muldiv_unit (start/funct3/operands/kill in, busy/done/result out).
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, rs1_data, rs2_data, kill,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, kill,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_core.sv
// muldiv_core: iterative 2*XLEN accumulator, one shift-add (mul) or
// restoring-subtract (div) step per step pulse. Ports: clk, rst, load, step, is_div, a, b, acc.
module muldiv_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] acc
);

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   b_q;
  logic              div_q;

  // multiply: {hi,lo}, lo holds the multiplier, shifted out LSB first
  logic [XLEN:0]     sum;
  // divide: {rem,quot}, dividend shifted into rem MSB first
  logic [2*XLEN:0]   sh;
  logic [XLEN:0]     rem;
  logic [XLEN+1:0]   diff;
  logic              unused_bits;

  always_comb begin
    sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
           (acc_q[0] ? {1'b0, b_q} : '0);
    sh   = {acc_q, 1'b0};
    rem  = sh[2*XLEN:XLEN];
    diff = {1'b0, rem} - {2'b0, b_q};
  end

  // diff[XLEN] is always 0 when no borrow occurs; rem[XLEN]
  // is 0 whenever the subtract is skipped
  assign unused_bits = diff[XLEN] ^ rem[XLEN];

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      acc_q <= {{XLEN{1'b0}}, a};
      b_q   <= b;
      div_q <= is_div;
    end else if (step) begin
      if (!div_q)
        acc_q <= {sum, acc_q[XLEN-1:1]};
      else if (!diff[XLEN+1])
        acc_q <= {diff[XLEN-1:0], sh[XLEN-1:1], 1'b1};
      else
        acc_q <= {rem[XLEN-1:0], sh[XLEN-1:0]};
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M multiply/divide unit; FSM, operand capture, sign
// handling and special cases. Ports: clk, rst (sync, active-low), bus (muldiv_if.slave).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic clk,
  input  logic rst,
  muldiv_if.slave bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [2:0]      op;
  logic            neg_res;
  logic            div0;
  logic            ovf;
  logic [XLEN-1:0] dvd;
  logic [XLEN-1:0] result_q;
  logic            done_q;

  logic            capture;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] neg_acc;
  logic [XLEN-1:0] fin;

  assign capture = (state == S_IDLE) && bus.start && !bus.kill;

  always_comb begin
    a_neg = rs1_signed(bus.funct3) && bus.rs1_data[XLEN-1];
    b_neg = rs2_signed(bus.funct3) && bus.rs2_data[XLEN-1];
    a_mag = a_neg ? (~bus.rs1_data + 1'b1) : bus.rs1_data;
    b_mag = b_neg ? (~bus.rs2_data + 1'b1) : bus.rs2_data;
  end

  muldiv_core #(
    .XLEN(XLEN)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (capture),
    .step   ((state == S_CALC) && !bus.kill),
    .is_div (is_div_op(bus.funct3)),
    .a      (a_mag),
    .b      (b_mag),
    .acc    (acc)
  );

  // low half of the 2*XLEN negation equals the XLEN-bit negation,
  // so one negator serves quotient and high product
  assign neg_acc = ~acc + 1'b1;

  always_comb begin
    fin = acc[XLEN-1:0];
    case (op)
      F3_MUL:
        fin = acc[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:
        fin = neg_res ? neg_acc[2*XLEN-1:XLEN]
                      : acc[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:
        if (div0)
          fin = '1;
        else if (ovf)
          fin = MIN_INT;
        else
          fin = neg_res ? neg_acc[XLEN-1:0]
                        : acc[XLEN-1:0];
      F3_REM, F3_REMU:
        if (div0)
          fin = dvd;
        else if (ovf)
          fin = '0;
        else
          fin = neg_res ? (~acc[2*XLEN-1:XLEN] + 1'b1)
                        : acc[2*XLEN-1:XLEN];
      default:
        fin = acc[XLEN-1:0];
    endcase
  end

  // DONE spans two cycles: the first registers the signed result and
  // raises done, the second drops done and returns to IDLE
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op       <= '0;
      neg_res  <= 1'b0;
      div0     <= 1'b0;
      ovf      <= 1'b0;
      dvd      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else if (bus.kill) begin
      state  <= S_IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op      <= bus.funct3;
            neg_res <= (bus.funct3 == F3_REM) ? a_neg
                                              : (a_neg ^ b_neg);
            div0    <= (bus.rs2_data == '0);
            ovf     <= (bus.funct3 == F3_DIV) &&
                       (bus.rs1_data == MIN_INT) &&
                       (bus.rs2_data == '1);
            dvd     <= bus.rs1_data;
            cnt     <= '0;
            state   <= S_CALC;
          end
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST)
            state <= S_DONE;
        end
        S_DONE: begin
          if (!done_q) begin
            done_q   <= 1'b1;
            result_q <= fin;
          end else begin
            done_q <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = (state != S_IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule
